// File: rtl/multicycle_control.sv
// multicycle_control
//   Multi-cycle sequencer for the MIPS datapath. Steps each instruction through
//   fetch, decode, execute, memory and write-back states, driving the shared
//   ALU / shared memory datapath. Waits in FETCH, MEMRD and MEMWR until the
//   memory reports completion.
//
//   Build option: define MC_MULT_EN to stretch R-type mult (funct 011000)
//   through an extra MULT wait state of MULT_CYCLES cycles (legal 1..16).
//   Without it, mult is treated like any other R-type instruction.
//
// Ports
//   clk_i, rst_i         clock (rising edge), synchronous active-high reset
//   Op_i, Funct_i        IR[31:26], IR[5:0]
//   Zero_i               ALU zero flag (qualifies the branch PC write)
//   MemReady_i           memory completes the current access this cycle
//   PCWr_o, PCSrc_o      PC write enable / PC source (00 ALU, 01 ALUOut, 10 jump)
//   IorD_o               memory address select (0 PC, 1 ALUOut)
//   MemRd_o, MemWr_o     memory strobes
//   IRWr_o               instruction register write
//   RegDst_o, MemtoReg_o, RegWr_o   register file write controls
//   ALUSrcA_o, ALUSrcB_o, ALUOp_o   ALU operand / operation selects
//   Illegal_o            one-cycle pulse in DECODE on an unsupported opcode
//   State_o              current state code (debug)
module multicycle_control #(
  parameter int MULT_CYCLES = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] Op_i,
  input  logic [5:0] Funct_i,
  input  logic       Zero_i,
  input  logic       MemReady_i,
  output logic       PCWr_o,
  output logic [1:0] PCSrc_o,
  output logic       IorD_o,
  output logic       MemRd_o,
  output logic       MemWr_o,
  output logic       IRWr_o,
  output logic       RegDst_o,
  output logic       MemtoReg_o,
  output logic       RegWr_o,
  output logic       ALUSrcA_o,
  output logic [1:0] ALUSrcB_o,
  output logic [1:0] ALUOp_o,
  output logic       Illegal_o,
  output logic [3:0] State_o
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_RTWB   = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_JUMP   = 4'd9;
  localparam logic [3:0] S_ADDIWB = 4'd10;
  localparam logic [3:0] S_MULT   = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  logic [3:0] state_reg, state_next;
  logic [3:0] out_state;

  // Raw decoded strobes, before the reset gate.
  logic pcwr_dec, memrd_dec, memwr_dec, irwr_dec, regwr_dec, illegal_dec;

`ifdef MC_MULT_EN
  localparam logic [5:0] FUNCT_MULT = 6'b011000;
  localparam logic [3:0] MULT_LAST  = 4'(MULT_CYCLES - 1);

  logic [3:0] mult_cnt_reg, mult_cnt_next;
  logic       mult_done;

  assign mult_done = (mult_cnt_reg == MULT_LAST);

  // Counter only runs inside MULT and returns to zero on the exit cycle,
  // so every mult starts counting from 0.
  always_comb begin
    mult_cnt_next = '0;
    if (state_reg == S_MULT && !mult_done) begin
      mult_cnt_next = mult_cnt_reg + 4'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mult_cnt_reg <= '0;
    end else begin
      mult_cnt_reg <= mult_cnt_next;
    end
  end
`else
  // Funct and the multiply length only matter with the multiply wait state.
  logic unused_mult;
  assign unused_mult = ^{Funct_i, 5'(MULT_CYCLES)};
`endif

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_FETCH:  if (MemReady_i) state_next = S_DECODE;
      S_DECODE: begin
        case (Op_i)
          OP_RTYPE:             state_next = S_EXEC;
          OP_LW, OP_SW, OP_ADDI: state_next = S_MEMADR;
          OP_BEQ:               state_next = S_BRANCH;
          OP_J:                 state_next = S_JUMP;
          default:              state_next = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        case (Op_i)
          OP_LW:   state_next = S_MEMRD;
          OP_SW:   state_next = S_MEMWR;
          default: state_next = S_ADDIWB;
        endcase
      end
      S_MEMRD:  if (MemReady_i) state_next = S_MEMWB;
      S_MEMWR:  if (MemReady_i) state_next = S_FETCH;
`ifdef MC_MULT_EN
      S_EXEC:   state_next = (Funct_i == FUNCT_MULT) ? S_MULT : S_RTWB;
      S_MULT:   if (mult_done) state_next = S_RTWB;
`else
      S_EXEC:   state_next = S_RTWB;
`endif
      default:  state_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= S_FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  // During reset the outputs decode as FETCH regardless of the registered
  // state, so an aborted instruction cannot leak its controls.
  assign out_state = rst_i ? S_FETCH : state_reg;

  always_comb begin
    pcwr_dec    = 1'b0;
    memrd_dec   = 1'b0;
    memwr_dec   = 1'b0;
    irwr_dec    = 1'b0;
    regwr_dec   = 1'b0;
    illegal_dec = 1'b0;
    PCSrc_o     = 2'b00;
    IorD_o      = 1'b0;
    RegDst_o    = 1'b0;
    MemtoReg_o  = 1'b0;
    ALUSrcA_o   = 1'b0;
    ALUSrcB_o   = 2'b00;
    ALUOp_o     = 2'b00;
    case (out_state)
      S_FETCH: begin
        memrd_dec = 1'b1;
        ALUSrcB_o = 2'b01;
        ALUOp_o   = 2'b01;
        // IR load and PC+4 happen only on the cycle the read completes.
        irwr_dec  = MemReady_i;
        pcwr_dec  = MemReady_i;
      end
      S_DECODE: begin
        ALUSrcB_o   = 2'b11;
        ALUOp_o     = 2'b01;
        illegal_dec = !(Op_i inside {OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_BEQ, OP_J});
      end
      S_MEMADR: begin
        ALUSrcA_o = 1'b1;
        ALUSrcB_o = 2'b10;
        ALUOp_o   = 2'b01;
      end
      S_MEMRD: begin
        memrd_dec = 1'b1;
        IorD_o    = 1'b1;
      end
      S_MEMWB: begin
        MemtoReg_o = 1'b1;
        regwr_dec  = 1'b1;
      end
      S_MEMWR: begin
        memwr_dec = 1'b1;
        IorD_o    = 1'b1;
      end
`ifdef MC_MULT_EN
      S_EXEC, S_MULT: begin
`else
      S_EXEC: begin
`endif
        ALUSrcA_o = 1'b1;
      end
      S_RTWB: begin
        RegDst_o  = 1'b1;
        regwr_dec = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA_o = 1'b1;
        ALUOp_o   = 2'b10;
        PCSrc_o   = 2'b01;
        pcwr_dec  = Zero_i;
      end
      S_JUMP: begin
        PCSrc_o  = 2'b10;
        pcwr_dec = 1'b1;
      end
      S_ADDIWB: begin
        regwr_dec = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign PCWr_o    = pcwr_dec    & ~rst_i;
  assign MemRd_o   = memrd_dec   & ~rst_i;
  assign MemWr_o   = memwr_dec   & ~rst_i;
  assign IRWr_o    = irwr_dec    & ~rst_i;
  assign RegWr_o   = regwr_dec   & ~rst_i;
  assign Illegal_o = illegal_dec & ~rst_i;
  assign State_o   = out_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Testbench for multicycle_control. Each test drives one instruction sequence
// cycle by cycle; the expected output vector for each cycle is pushed to a
// scoreboard queue when the stimulus is applied and popped when sampled.
module tb_multicycle_control;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [5:0] Op_i, Funct_i;
  logic       Zero_i, MemReady_i;
  logic       PCWr_o, IorD_o, MemRd_o, MemWr_o, IRWr_o, RegDst_o, MemtoReg_o;
  logic       RegWr_o, ALUSrcA_o, Illegal_o;
  logic [1:0] PCSrc_o, ALUSrcB_o, ALUOp_o;
  logic [3:0] State_o;

  int checks   = 0;
  int failures = 0;
  logic [19:0] exp_q [$];
  logic [19:0] got, want;

  multicycle_control #(.MULT_CYCLES(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .Op_i(Op_i), .Funct_i(Funct_i),
    .Zero_i(Zero_i), .MemReady_i(MemReady_i), .PCWr_o(PCWr_o),
    .PCSrc_o(PCSrc_o), .IorD_o(IorD_o), .MemRd_o(MemRd_o), .MemWr_o(MemWr_o),
    .IRWr_o(IRWr_o), .RegDst_o(RegDst_o), .MemtoReg_o(MemtoReg_o),
    .RegWr_o(RegWr_o), .ALUSrcA_o(ALUSrcA_o), .ALUSrcB_o(ALUSrcB_o),
    .ALUOp_o(ALUOp_o), .Illegal_o(Illegal_o), .State_o(State_o)
  );

  always #5 clk_i = ~clk_i;

  // {State, PCWr, PCSrc, IorD, MemRd, MemWr, IRWr, RegDst, MemtoReg, RegWr,
  //  ALUSrcA, ALUSrcB, ALUOp, Illegal}
  wire [19:0] obs = {State_o, PCWr_o, PCSrc_o, IorD_o, MemRd_o, MemWr_o, IRWr_o,
                     RegDst_o, MemtoReg_o, RegWr_o, ALUSrcA_o, ALUSrcB_o,
                     ALUOp_o, Illegal_o};

  // Control table of the sequencer, written from the state descriptions.
  function automatic logic [19:0] model(input logic [3:0] st, input logic rst,
                                        input logic ready, input logic zero,
                                        input logic [5:0] op);
    logic pcwr, iord, memrd, memwr, irwr, regdst, m2r, regwr, srca, ill;
    logic [1:0] pcsrc, srcb, aluop;
    logic [3:0] so;
    {pcwr, iord, memrd, memwr, irwr, regdst, m2r, regwr, srca, ill} = '0;
    pcsrc = 2'b00; srcb = 2'b00; aluop = 2'b00; so = st;
    if (rst) begin
      so = 4'd0; srcb = 2'b01; aluop = 2'b01;
    end else begin
      case (st)
        4'd0:  begin memrd = 1; srcb = 2'b01; aluop = 2'b01; irwr = ready; pcwr = ready; end
        4'd1:  begin srcb = 2'b11; aluop = 2'b01;
                     ill = !(op == 6'b000000 || op == 6'b100011 || op == 6'b101011 ||
                             op == 6'b001000 || op == 6'b000100 || op == 6'b000010); end
        4'd2:  begin srca = 1; srcb = 2'b10; aluop = 2'b01; end
        4'd3:  begin memrd = 1; iord = 1; end
        4'd4:  begin m2r = 1; regwr = 1; end
        4'd5:  begin memwr = 1; iord = 1; end
        4'd6, 4'd11: begin srca = 1; end
        4'd7:  begin regdst = 1; regwr = 1; end
        4'd8:  begin srca = 1; aluop = 2'b10; pcsrc = 2'b01; pcwr = zero; end
        4'd9:  begin pcsrc = 2'b10; pcwr = 1; end
        4'd10: begin regwr = 1; end
        default: ;
      endcase
    end
    return {so, pcwr, pcsrc, iord, memrd, memwr, irwr, regdst, m2r, regwr,
            srca, srcb, aluop, ill};
  endfunction

  // Apply one cycle of stimulus away from the rising edge and queue its expectation.
  task automatic drive(input logic rst, input logic [5:0] op, input logic [5:0] funct,
                       input logic zero, input logic ready, input logic [3:0] exp_state);
    @(negedge clk_i);
    rst_i = rst; Op_i = op; Funct_i = funct; Zero_i = zero; MemReady_i = ready;
    exp_q.push_back(model(exp_state, rst, ready, zero, op));
    #2;
  endtask

  task automatic test_reset();
    logic [3:0] seq [$];
    logic       rs  [$];
    logic       rdy [$];
    seq = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd0, 4'd0, 4'd0};
    rs  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < seq.size(); i++) begin
      drive(rs[i], 6'b100011, 6'd0, 1'b0, rdy[i], seq[i]);
      got = obs; want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL reset step%0d got=%05h want=%05h", i, got, want);
      end
    end
  endtask

  task automatic test_add();
    logic [3:0] seq [$];
    seq = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
    for (int i = 0; i < seq.size(); i++) begin
      // Last step is the next fetch, held off with MemReady low.
      drive(1'b0, 6'b000000, 6'b100000, 1'b0, (i < 4), seq[i]);
      got = obs; want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL add step%0d got=%05h want=%05h", i, got, want);
      end
    end
  endtask

  task automatic test_lw_wait();
    logic [3:0] seq [$];
    logic       rdy [$];
    seq = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd4};
    rdy = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < seq.size(); i++) begin
      drive(1'b0, 6'b100011, 6'd0, 1'b0, rdy[i], seq[i]);
      got = obs; want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL lw_wait step%0d got=%05h want=%05h", i, got, want);
      end
    end
  endtask

  task automatic test_beq();
    for (int z = 1; z >= 0; z--) begin
      for (int i = 0; i < 3; i++) begin
        drive(1'b0, 6'b000100, 6'd0, z[0], 1'b1, (i == 2) ? 4'd8 : 4'(i));
        got = obs; want = exp_q.pop_front(); checks++;
        if (got !== want) begin
          failures++;
          $display("FAIL beq_zero%0d step%0d got=%05h want=%05h", z, i, got, want);
        end
      end
    end
  endtask

  task automatic test_illegal();
    logic [3:0] seq [$];
    seq = '{4'd0, 4'd1, 4'd0};
    for (int i = 0; i < seq.size(); i++) begin
      drive(1'b0, 6'b111111, 6'd0, 1'b1, (i < 2), seq[i]);
      got = obs; want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL illegal step%0d got=%05h want=%05h", i, got, want);
      end
    end
  endtask

  // sw with one memory wait, then addi, then j, with no gaps between them.
  task automatic test_back_to_back();
    logic [3:0] seq [$];
    logic [5:0] ops [$];
    logic       rdy [$];
    seq = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd0, 4'd1, 4'd2, 4'd10, 4'd0, 4'd1, 4'd9};
    ops = '{6'b101011, 6'b101011, 6'b101011, 6'b101011, 6'b101011,
            6'b001000, 6'b001000, 6'b001000, 6'b001000,
            6'b000010, 6'b000010, 6'b000010};
    rdy = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < seq.size(); i++) begin
      drive(1'b0, ops[i], 6'd0, 1'b0, rdy[i], seq[i]);
      got = obs; want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL back_to_back step%0d got=%05h want=%05h", i, got, want);
      end
    end
  endtask

  task automatic test_mult();
    logic [3:0] seq [$];
`ifdef MC_MULT_EN
    seq = '{4'd0, 4'd1, 4'd6, 4'd11, 4'd11, 4'd11, 4'd11, 4'd7, 4'd0};
`else
    seq = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
`endif
    for (int i = 0; i < seq.size(); i++) begin
      drive(1'b0, 6'b000000, 6'b011000, 1'b0, (i < seq.size() - 1), seq[i]);
      got = obs; want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL mult step%0d got=%05h want=%05h", i, got, want);
      end
    end
  endtask

  initial begin
    rst_i = 1'b1; Op_i = '0; Funct_i = '0; Zero_i = 1'b0; MemReady_i = 1'b0;
    test_reset();
    test_add();
    test_lw_wait();
    test_beq();
    test_illegal();
    test_back_to_back();
    test_mult();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
